// File: rtl/uart_tx_word.sv
// 16-bit word UART transmitter: two 8N1 bytes, high byte first, optional idle gap between bytes.
// All outputs registered; a request is accepted only while idle and the word is latched on accept.
module uart_tx_word #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int GAP_BITS     = 0
) (
  input  logic        CLOCK_50,
  input  logic        rst,
  input  logic        tx_start,
  input  logic [15:0] tx_data,
  output logic        tx_pin,
  output logic        tx_busy,
  output logic        tx_done
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    GAP_LAST   = (GAP_BITS > 0) ? 4'(GAP_BITS - 1) : 4'd0;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [3:0]      gap_cnt_q, gap_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      lo_byte_q, lo_byte_d;
  logic            byte_sel_q, byte_sel_d;
  logic            pin_q, pin_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    bit_idx_d  = bit_idx_q;
    gap_cnt_d  = gap_cnt_q;
    shift_d    = shift_q;
    lo_byte_d  = lo_byte_q;
    byte_sel_d = byte_sel_q;
    pin_d      = pin_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        pin_d = 1'b1;
        if (tx_start) begin
          shift_d    = tx_data[15:8];
          lo_byte_d  = tx_data[7:0];
          byte_sel_d = 1'b0;
          busy_d     = 1'b1;
          timer_d    = '0;
          pin_d      = 1'b0;
          state_d    = START;
        end
      end
      START: begin
        if (timer_q == TIMER_LAST) begin
          timer_d   = '0;
          bit_idx_d = 3'd0;
          pin_d     = shift_q[0];
          state_d   = DATA;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      DATA: begin
        if (timer_q == TIMER_LAST) begin
          timer_d = '0;
          if (bit_idx_q == 3'd7) begin
            pin_d   = 1'b1;
            state_d = STOP;
          end else begin
            // Shift right so the next bit to send is always in shift_q[0].
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            pin_d     = shift_q[1];
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      STOP: begin
        if (timer_q == TIMER_LAST) begin
          timer_d = '0;
          if (byte_sel_q) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pin_d   = 1'b1;
            state_d = IDLE;
          end else if (GAP_BITS > 0) begin
            gap_cnt_d = 4'd0;
            pin_d     = 1'b1;
            state_d   = GAP;
          end else begin
            shift_d    = lo_byte_q;
            byte_sel_d = 1'b1;
            pin_d      = 1'b0;
            state_d    = START;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      GAP: begin
        if (timer_q == TIMER_LAST) begin
          timer_d = '0;
          if (gap_cnt_q == GAP_LAST) begin
            shift_d    = lo_byte_q;
            byte_sel_d = 1'b1;
            pin_d      = 1'b0;
            state_d    = START;
          end else begin
            gap_cnt_d = gap_cnt_q + 4'd1;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        pin_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      bit_idx_q  <= 3'd0;
      gap_cnt_q  <= 4'd0;
      shift_q    <= 8'd0;
      lo_byte_q  <= 8'd0;
      byte_sel_q <= 1'b0;
      pin_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      gap_cnt_q  <= gap_cnt_d;
      shift_q    <= shift_d;
      lo_byte_q  <= lo_byte_d;
      byte_sel_q <= byte_sel_d;
      pin_q      <= pin_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx_pin  = pin_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_word.sv
// Directed bench for uart_tx_word with CLKS_PER_BIT=4: one instance without gap, one with GAP_BITS=2.
`timescale 1ns/1ps
module tb_uart_tx_word;

  localparam int C = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_start;
  logic [15:0] tx_data;
  logic        pin_0, busy_0, done_0;
  logic        pin_g, busy_g, done_g;
  logic        g_sel;
  logic        pin, busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_tx_word #(.CLKS_PER_BIT(C), .GAP_BITS(0)) dut0 (
    .CLOCK_50(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
    .tx_pin(pin_0), .tx_busy(busy_0), .tx_done(done_0)
  );

  uart_tx_word #(.CLKS_PER_BIT(C), .GAP_BITS(2)) dut_g (
    .CLOCK_50(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
    .tx_pin(pin_g), .tx_busy(busy_g), .tx_done(done_g)
  );

  always_comb begin
    pin  = g_sel ? pin_g  : pin_0;
    busy = g_sel ? busy_g : busy_0;
    done = g_sel ? done_g : done_0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) tick();
  endtask

  // Expected line level n cycles after the accepting edge.
  function automatic logic exp_pin(input logic [15:0] w, input int gap, input int n);
    logic [7:0] b;
    int m;
    int k;
    if (n < 10*C) begin
      b = w[15:8];
      m = n;
    end else if (n < 10*C + gap*C) begin
      return 1'b1;
    end else if (n < 20*C + gap*C) begin
      b = w[7:0];
      m = n - 10*C - gap*C;
    end else begin
      return 1'b1;
    end
    k = m / C;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  // Caller has just passed the accepting edge (n=0). Checks every cycle up to the done edge.
  task automatic check_word(input logic [15:0] w, input int gap, input int poke,
                            input logic chain, input logic [15:0] nxt, input string tag);
    int last;
    int busy_n;
    int done_n;
    int done_at;
    logic e;
    last    = (20 + gap) * C;
    busy_n  = 0;
    done_n  = 0;
    done_at = -1;
    for (int n = 0; n <= last; n++) begin
      if (n > 0) tick();
      e = exp_pin(w, gap, n);
      n_cmp++;
      if (pin !== e) begin
        n_bad++;
        $display("FAIL %s pin n=%0d got %b want %b", tag, n, pin, e);
      end
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1) begin
        done_n++;
        done_at = n;
      end
      if (poke >= 0 && n == poke - 1) begin
        tx_start = 1'b1;
        tx_data  = 16'hFFFF;
      end
      if (poke >= 0 && n == poke) tx_start = 1'b0;
      if (chain && n == last) tx_data = nxt;
    end
    n_cmp++;
    if (busy_n !== last) begin
      n_bad++;
      $display("FAIL %s busy_cycles got %0d want %0d", tag, busy_n, last);
    end
    n_cmp++;
    if (done_n !== 1 || done_at !== last) begin
      n_bad++;
      $display("FAIL %s done got count=%0d at=%0d want count=1 at=%0d", tag, done_n, done_at, last);
    end
  endtask

  task automatic start_word(input logic [15:0] w);
    tx_data  = w;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tx_start = 1'b0;
    tx_data = 16'h0000;
    g_sel = 1'b0;
    idle(3);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      n_cmp++;
      if (pin_0 !== 1'b1 || busy_0 !== 1'b0 || done_0 !== 1'b0 ||
          pin_g !== 1'b1 || busy_g !== 1'b0 || done_g !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_idle i=%0d got pin=%b busy=%b done=%b want 1 0 0", i, pin_0, busy_0, done_0);
      end
    end
    // Reset and start on the same edge: the request is dropped.
    rst = 1'b1;
    tx_start = 1'b1;
    tx_data = 16'hA5A5;
    tick();
    rst = 1'b0;
    tx_start = 1'b0;
    tick();
    n_cmp++;
    if (pin_0 !== 1'b1 || busy_0 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_vs_start got pin=%b busy=%b want 1 0", pin_0, busy_0);
    end
  endtask

  task automatic test_single();
    g_sel = 1'b0;
    idle(20);
    start_word(16'hA355);
    check_word(16'hA355, 0, -1, 1'b0, 16'h0000, "single");
  endtask

  task automatic test_gap();
    g_sel = 1'b1;
    idle(20);
    start_word(16'h8001);
    check_word(16'h8001, 2, -1, 1'b0, 16'h0000, "gap");
  endtask

  task automatic test_lockout();
    g_sel = 1'b0;
    idle(20);
    start_word(16'h1234);
    check_word(16'h1234, 0, 10, 1'b0, 16'h0000, "lockout");
    idle(10);
    n_cmp++;
    if (pin_0 !== 1'b1 || busy_0 !== 1'b0) begin
      n_bad++;
      $display("FAIL lockout_after got pin=%b busy=%b want 1 0", pin_0, busy_0);
    end
  endtask

  task automatic test_back_to_back();
    g_sel = 1'b0;
    idle(20);
    tx_data  = 16'h00FF;
    tx_start = 1'b1;
    tick();
    check_word(16'h00FF, 0, -1, 1'b1, 16'hFF00, "b2b_first");
    tick();
    tx_start = 1'b0;
    check_word(16'hFF00, 0, -1, 1'b0, 16'h0000, "b2b_second");
  endtask

  task automatic test_reset_mid();
    int dones;
    g_sel = 1'b0;
    idle(20);
    start_word(16'hC3A5);
    for (int n = 1; n <= 30; n++) tick();
    rst = 1'b1;
    tick();
    n_cmp++;
    if (pin_0 !== 1'b1 || busy_0 !== 1'b0 || done_0 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid got pin=%b busy=%b done=%b want 1 0 0", pin_0, busy_0, done_0);
    end
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (done_0 === 1'b1 || pin_0 !== 1'b1 || busy_0 !== 1'b0) dones++;
    end
    n_cmp++;
    if (dones !== 0) begin
      n_bad++;
      $display("FAIL reset_mid_quiet got %0d bad cycles want 0", dones);
    end
    start_word(16'h5AC3);
    check_word(16'h5AC3, 0, -1, 1'b0, 16'h0000, "after_reset");
  endtask

  initial begin
    test_reset();
    test_single();
    test_gap();
    test_lockout();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
